riscv_dmem_reqq: RTL and testbench

Parametrised in-order data-memory request queue between the CPU memory stage and the data-cache/BIU path. It generalises the fixed two-entry data buffer in four ways:
- configurable depth;
- multiple issued-but-unacknowledged (outstanding) requests;
- flush of unissued entries;
- enqueue-time misalignment detection, with misaligned entries retired locally in program order so they never reach memory.

---
 rtl/riscv_dmem_reqq_if.sv | 69 ++++++
 rtl/riscv_dmem_reqq.sv | 200 ++++++++++++++++++++
 tb/tb_riscv_dmem_reqq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_reqq_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_reqq_if
//  Purpose  : Bundle of the CPU-side enqueue port, the downstream issue port
//             and the retire/status port of the data-memory request queue.
//  Params   : XLEN - address/data width
//             OW   - width of the outstanding counter,
//                    $clog2(MAX_OUTSTANDING+1) of the attached queue
//  Modports : master - memory stage / BIU environment driving the queue
//             slave  - the request queue itself
//  Ports    : enqueue  req_i adr_i size_i lock_i prot_i we_i d_i -> rdy_o
//             flush    flush_i
//             issue    req_o adr_o size_o lock_o prot_o we_o d_o <- stall_i
//             complete ack_i err_i q_i
//             retire   ack_o err_o misaligned_o q_o
//             status   empty_o full_o outstanding_o
//  Revision : 1.0 - initial release
// ============================================================================
interface riscv_dmem_reqq_if #(
   parameter int XLEN = 32,
   parameter int OW   = 2
);
   // size encoding: 0 BYTE, 1 HWORD, 2 WORD, 3 DWORD; prot is 3 opaque bits
   logic            req_i;
   logic [XLEN-1:0] adr_i;
   logic [1:0]      size_i;
   logic            lock_i;
   logic [2:0]      prot_i;
   logic            we_i;
   logic [XLEN-1:0] d_i;
   logic            rdy_o;
   logic            flush_i;

   logic            req_o;
   logic [XLEN-1:0] adr_o;
   logic [1:0]      size_o;
   logic            lock_o;
   logic [2:0]      prot_o;
   logic            we_o;
   logic [XLEN-1:0] d_o;
   logic            stall_i;

   logic            ack_i;
   logic            err_i;
   logic [XLEN-1:0] q_i;

   logic            ack_o;
   logic            err_o;
   logic            misaligned_o;
   logic [XLEN-1:0] q_o;
   logic            empty_o;
   logic            full_o;
   logic [OW-1:0]   outstanding_o;

   modport master (
      output req_i, adr_i, size_i, lock_i, prot_i, we_i, d_i, flush_i,
             stall_i, ack_i, err_i, q_i,
      input  rdy_o, req_o, adr_o, size_o, lock_o, prot_o, we_o, d_o,
             ack_o, err_o, misaligned_o, q_o, empty_o, full_o, outstanding_o
   );

   modport slave (
      input  req_i, adr_i, size_i, lock_i, prot_i, we_i, d_i, flush_i,
             stall_i, ack_i, err_i, q_i,
      output rdy_o, req_o, adr_o, size_o, lock_o, prot_o, we_o, d_o,
             ack_o, err_o, misaligned_o, q_o, empty_o, full_o, outstanding_o
   );
endinterface
`default_nettype wire

// File: rtl/riscv_dmem_reqq.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_reqq
//  Purpose  : In-order data-memory request queue between the CPU memory stage
//             and the data-cache/BIU. Circular buffer with separate enqueue,
//             issue and retire pointers, up to MAX_OUTSTANDING issued but
//             unretired requests, flush of unissued entries, and local
//             in-order retirement of misaligned requests.
//  Params   : XLEN (32), DEPTH (4, power of 2, >=2),
//             MAX_OUTSTANDING (2, 1..DEPTH)
//  Ports    : clk_i  - clock, rising edge
//             rst_i  - synchronous active-high reset
//             bus    - riscv_dmem_reqq_if.slave (enqueue, issue, retire,
//                      flush and status signals)
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem_reqq #(
   parameter int XLEN            = 32,
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   riscv_dmem_reqq_if.slave    bus
);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam int c_os_w  = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
   localparam logic [c_os_w-1:0]  c_os_one  = c_os_w'(1);
   localparam logic [c_os_w-1:0]  c_max_os  = c_os_w'(MAX_OUTSTANDING);

   localparam logic [1:0] c_size_hword = 2'd1;
   localparam logic [1:0] c_size_word  = 2'd2;
   localparam logic [1:0] c_size_dword = 2'd3;

   // entry storage
   logic [XLEN-1:0] r_adr  [DEPTH];
   logic [1:0]      r_size [DEPTH];
   logic            r_lock [DEPTH];
   logic [2:0]      r_prot [DEPTH];
   logic            r_we   [DEPTH];
   logic [XLEN-1:0] r_d    [DEPTH];
   logic            r_mis  [DEPTH];

   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_iss_ptr;
   logic [c_ptr_w-1:0] r_ret_ptr;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_os_w-1:0]  r_inflight;
   // a locked access may only be in flight alone, so one flag suffices
   logic               r_lock_os;

   logic               r_ack;
   logic               r_err;
   logic               r_mis_ret;
   logic [XLEN-1:0]    r_q;

   logic [c_cnt_w-1:0] w_pend;
   logic               w_pend_nz;
   logic               w_os_zero;
   logic               w_head_mis;
   logic               w_head_lock;
   logic               w_full;
   logic               w_enq;
   logic               w_enq_mis;
   logic               w_req;
   logic               w_issue;
   logic               w_mis_ret;
   logic               w_retire;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic [c_os_w-1:0]  w_inflight_nxt;

   assign w_pend      = r_cnt - c_cnt_w'(r_inflight);
   assign w_pend_nz   = (w_pend != '0);
   assign w_os_zero   = (r_inflight == '0);
   assign w_head_mis  = r_mis[r_iss_ptr];
   assign w_head_lock = r_lock[r_iss_ptr];
   assign w_full      = (r_cnt == c_depth);

   // rdy_o depends on state only, so a request arriving while full is lost
   // even when a retire frees a slot in the same cycle
   assign w_enq = bus.req_i & ~w_full & ~bus.flush_i;

   assign w_req = w_pend_nz & (r_inflight < c_max_os) & ~w_head_mis &
                  ~bus.flush_i & ~r_lock_os & (~w_head_lock | w_os_zero);
   assign w_issue = w_req & ~bus.stall_i;

   // waiting for an empty pipe keeps the local retire in program order
   assign w_mis_ret = w_pend_nz & w_head_mis & w_os_zero & ~bus.flush_i;
   assign w_retire  = (bus.ack_i | bus.err_i) & ~w_os_zero;

   always_comb begin
      w_enq_mis = 1'b0;
      case (bus.size_i)
         c_size_hword: w_enq_mis = bus.adr_i[0];
         c_size_word:  w_enq_mis = |bus.adr_i[1:0];
         c_size_dword: w_enq_mis = |bus.adr_i[2:0];
         default:      w_enq_mis = 1'b0;
      endcase
   end

   always_comb begin
      w_inflight_nxt = r_inflight;
      if (w_issue)  w_inflight_nxt = w_inflight_nxt + c_os_one;
      if (w_retire) w_inflight_nxt = w_inflight_nxt - c_os_one;

      w_cnt_nxt = r_cnt;
      if (w_enq)     w_cnt_nxt = w_cnt_nxt + c_cnt_one;
      if (w_retire)  w_cnt_nxt = w_cnt_nxt - c_cnt_one;
      if (w_mis_ret) w_cnt_nxt = w_cnt_nxt - c_cnt_one;
      // flush keeps only in-flight entries; a concurrent completion still retires
      if (bus.flush_i)
         w_cnt_nxt = c_cnt_w'(r_inflight) - (w_retire ? c_cnt_one : '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_adr[i]  <= '0;
            r_size[i] <= '0;
            r_lock[i] <= 1'b0;
            r_prot[i] <= '0;
            r_we[i]   <= 1'b0;
            r_d[i]    <= '0;
            r_mis[i]  <= 1'b0;
         end
      end else if (w_enq) begin
         r_adr[r_wr_ptr]  <= bus.adr_i;
         r_size[r_wr_ptr] <= bus.size_i;
         r_lock[r_wr_ptr] <= bus.lock_i;
         r_prot[r_wr_ptr] <= bus.prot_i;
         r_we[r_wr_ptr]   <= bus.we_i;
         r_d[r_wr_ptr]    <= bus.d_i;
         r_mis[r_wr_ptr]  <= w_enq_mis;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_iss_ptr  <= '0;
         r_ret_ptr  <= '0;
         r_cnt      <= '0;
         r_inflight <= '0;
         r_lock_os  <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_mis_ret  <= 1'b0;
         r_q        <= '0;
      end else begin
         if (bus.flush_i)
            r_wr_ptr <= r_iss_ptr;
         else if (w_enq)
            r_wr_ptr <= r_wr_ptr + c_ptr_one;

         if (w_issue | w_mis_ret)
            r_iss_ptr <= r_iss_ptr + c_ptr_one;
         if (w_retire | w_mis_ret)
            r_ret_ptr <= r_ret_ptr + c_ptr_one;

         r_cnt      <= w_cnt_nxt;
         r_inflight <= w_inflight_nxt;

         if (w_issue & w_head_lock)
            r_lock_os <= 1'b1;
         else if (w_retire)
            r_lock_os <= 1'b0;

         // err wins when both completion strobes arrive together
         r_ack     <= w_retire & ~bus.err_i;
         r_err     <= w_retire & bus.err_i;
         r_mis_ret <= w_mis_ret;
         if (w_retire & ~bus.err_i)
            r_q <= bus.q_i;
      end
   end

   assign bus.rdy_o         = ~w_full;
   assign bus.full_o        = w_full;
   assign bus.empty_o       = (r_cnt == '0);
   assign bus.outstanding_o = r_inflight;

   assign bus.req_o  = w_req;
   assign bus.adr_o  = r_adr[r_iss_ptr];
   assign bus.size_o = r_size[r_iss_ptr];
   assign bus.lock_o = r_lock[r_iss_ptr];
   assign bus.prot_o = r_prot[r_iss_ptr];
   assign bus.we_o   = r_we[r_iss_ptr];
   assign bus.d_o    = r_d[r_iss_ptr];

   assign bus.ack_o        = r_ack;
   assign bus.err_o        = r_err;
   assign bus.misaligned_o = r_mis_ret;
   assign bus.q_o          = r_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_reqq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_dmem_reqq
//  Purpose  : Directed self-checking bench for riscv_dmem_reqq
//             (XLEN 32, DEPTH 4, MAX_OUTSTANDING 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dmem_reqq;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_WORD = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_ack = 0;

   always #5 clk = ~clk;

   riscv_dmem_reqq_if #(.XLEN(32), .OW(2)) bus ();

   riscv_dmem_reqq #(
      .XLEN            (32),
      .DEPTH           (4),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [31:0] a, input logic [1:0] sz,
                          input logic we, input logic lk, input logic [31:0] d);
      bus.req_i  = 1'b1;
      bus.adr_i  = a;
      bus.size_i = sz;
      bus.we_i   = we;
      bus.lock_i = lk;
      bus.prot_i = 3'b000;
      bus.d_i    = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_i = 0; bus.adr_i = 0; bus.size_i = 0; bus.lock_i = 0;
      bus.prot_i = 0; bus.we_i = 0; bus.d_i = 0; bus.flush_i = 0;
      bus.stall_i = 0; bus.ack_i = 0; bus.err_i = 0; bus.q_i = 0;

      // ---------------- reset values
      tick(); tick();
      chk("rst_rdy",   bus.rdy_o, 1);
      chk("rst_empty", bus.empty_o, 1);
      chk("rst_full",  bus.full_o, 0);
      chk("rst_os",    bus.outstanding_o, 0);
      chk("rst_req",   bus.req_o, 0);
      chk("rst_ack",   bus.ack_o, 0);
      chk("rst_err",   bus.err_o, 0);
      chk("rst_mis",   bus.misaligned_o, 0);
      chk("rst_q",     bus.q_o, 0);
      chk("rst_adr",   bus.adr_o, 0);
      rst = 0;

      // ---------------- 4 WORD loads, two outstanding at most
      for (int i = 0; i < 4; i++) begin
         set_req(32'(i * 4), SZ_WORD, 0, 0, 0);
         tick();
      end
      bus.req_i = 0; settle();
      chk("s1_os2",     bus.outstanding_o, 2);
      chk("s1_full",    bus.full_o, 1);
      chk("s1_rdy",     bus.rdy_o, 0);
      chk("s1_req_lo",  bus.req_o, 0);
      bus.ack_i = 1; bus.q_i = 32'h1111; settle();
      chk("s1_req_wait", bus.req_o, 0);
      tick();
      bus.ack_i = 0; settle();
      chk("s1_ack1",  bus.ack_o, 1);
      chk("s1_q1",    bus.q_o, 32'h1111);
      chk("s1_req3",  bus.req_o, 1);
      chk("s1_adr3",  bus.adr_o, 32'h8);
      chk("s1_os1",   bus.outstanding_o, 1);
      tick();
      chk("s1_ack_lo", bus.ack_o, 0);
      chk("s1_req_max", bus.req_o, 0);
      chk("s1_os2b",  bus.outstanding_o, 2);
      bus.ack_i = 1; bus.q_i = 32'h2222; tick();
      bus.q_i = 32'h3333; settle();
      chk("s1_ack2",  bus.ack_o, 1);
      chk("s1_q2",    bus.q_o, 32'h2222);
      chk("s1_req4",  bus.req_o, 1);
      chk("s1_adr4",  bus.adr_o, 32'hC);
      tick();
      chk("s1_ack3",  bus.ack_o, 1);
      chk("s1_q3",    bus.q_o, 32'h3333);
      chk("s1_os_net", bus.outstanding_o, 1);
      chk("s1_req_none", bus.req_o, 0);
      bus.q_i = 32'h4444; tick();
      bus.ack_i = 0; settle();
      chk("s1_ack4",  bus.ack_o, 1);
      chk("s1_q4",    bus.q_o, 32'h4444);
      chk("s1_empty", bus.empty_o, 1);
      chk("s1_os0",   bus.outstanding_o, 0);
      tick();
      chk("s1_ack_end", bus.ack_o, 0);

      // ---------------- fill while stalled, 5th request dropped
      bus.stall_i = 1;
      for (int i = 0; i < 5; i++) begin
         set_req(32'h100 + 32'(i * 4), SZ_WORD, 0, 0, 0);
         tick();
      end
      bus.req_i = 0; settle();
      chk("s2_full",   bus.full_o, 1);
      chk("s2_rdy",    bus.rdy_o, 0);
      chk("s2_req",    bus.req_o, 1);
      chk("s2_adr",    bus.adr_o, 32'h100);
      chk("s2_os0",    bus.outstanding_o, 0);
      tick();
      chk("s2_hold_req", bus.req_o, 1);
      chk("s2_hold_adr", bus.adr_o, 32'h100);
      bus.stall_i = 0; bus.ack_i = 1; bus.q_i = 32'h0;
      n_ack = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.ack_o) n_ack++;
      end
      bus.ack_i = 0;
      chk("s2_nacks",  n_ack, 4);
      chk("s2_empty",  bus.empty_o, 1);

      // ---------------- misaligned head retired locally
      set_req(32'h2, SZ_WORD, 0, 0, 0); tick();
      set_req(32'h5, SZ_BYTE, 0, 0, 0); settle();
      chk("s3_no_issue", bus.req_o, 0);
      tick();
      bus.req_i = 0; settle();
      chk("s3_mis",     bus.misaligned_o, 1);
      chk("s3_req",     bus.req_o, 1);
      chk("s3_adr",     bus.adr_o, 32'h5);
      chk("s3_ack_lo",  bus.ack_o, 0);
      tick();
      chk("s3_mis_lo",  bus.misaligned_o, 0);
      chk("s3_os1",     bus.outstanding_o, 1);
      bus.ack_i = 1; bus.q_i = 32'h55; tick();
      bus.ack_i = 0;
      chk("s3_ack",     bus.ack_o, 1);
      chk("s3_empty",   bus.empty_o, 1);

      // ---------------- flush drops only the pending stores
      set_req(32'h10, SZ_WORD, 0, 0, 0); tick();
      set_req(32'h20, SZ_WORD, 1, 0, 32'hD0); settle();
      chk("s4_iss",     bus.req_o, 1);
      chk("s4_iss_adr", bus.adr_o, 32'h10);
      tick();
      bus.stall_i = 1;
      set_req(32'h24, SZ_WORD, 1, 0, 32'hD1); tick();
      set_req(32'h28, SZ_WORD, 1, 0, 32'hD2); tick();
      bus.req_i = 0; settle();
      chk("s4_full",    bus.full_o, 1);
      chk("s4_os1",     bus.outstanding_o, 1);
      chk("s4_st_adr",  bus.adr_o, 32'h20);
      chk("s4_st_we",   bus.we_o, 1);
      chk("s4_st_d",    bus.d_o, 32'hD0);
      bus.flush_i = 1; settle();
      chk("s4_flush_req", bus.req_o, 0);
      tick();
      bus.flush_i = 0; bus.stall_i = 0; settle();
      chk("s4_post_req", bus.req_o, 0);
      chk("s4_post_os",  bus.outstanding_o, 1);
      chk("s4_post_full", bus.full_o, 0);
      chk("s4_post_empty", bus.empty_o, 0);
      bus.ack_i = 1; bus.q_i = 32'h1010; tick();
      bus.ack_i = 0;
      chk("s4_ack",     bus.ack_o, 1);
      chk("s4_q",       bus.q_o, 32'h1010);
      chk("s4_empty",   bus.empty_o, 1);
      tick();
      chk("s4_no_more", bus.req_o, 0);
      chk("s4_ack_lo",  bus.ack_o, 0);

      // ---------------- locked store ordering
      set_req(32'h30, SZ_WORD, 0, 0, 0); tick();
      set_req(32'h20, SZ_WORD, 1, 1, 32'hAB); tick();
      set_req(32'h34, SZ_WORD, 0, 0, 0); settle();
      chk("s5_lock_wait", bus.req_o, 0);
      tick();
      bus.req_i = 0; settle();
      chk("s5_lock_wait2", bus.req_o, 0);
      chk("s5_os1",     bus.outstanding_o, 1);
      bus.ack_i = 1; tick();
      bus.ack_i = 0; settle();
      chk("s5_ack1",    bus.ack_o, 1);
      chk("s5_lk_req",  bus.req_o, 1);
      chk("s5_lk_adr",  bus.adr_o, 32'h20);
      chk("s5_lk_lock", bus.lock_o, 1);
      chk("s5_lk_we",   bus.we_o, 1);
      tick();
      chk("s5_blocked", bus.req_o, 0);
      chk("s5_os_lk",   bus.outstanding_o, 1);
      bus.ack_i = 1; tick();
      bus.ack_i = 0; settle();
      chk("s5_ack2",    bus.ack_o, 1);
      chk("s5_ld_req",  bus.req_o, 1);
      chk("s5_ld_adr",  bus.adr_o, 32'h34);
      chk("s5_ld_lock", bus.lock_o, 0);
      tick();
      bus.ack_i = 1; tick();
      bus.ack_i = 0;
      chk("s5_empty",   bus.empty_o, 1);

      // ---------------- error on second in-flight load, ack&err counts as err
      set_req(32'h40, SZ_WORD, 0, 0, 0); tick();
      set_req(32'h44, SZ_WORD, 0, 0, 0); tick();
      bus.req_i = 0; tick();
      chk("s6_os2",     bus.outstanding_o, 2);
      bus.ack_i = 1; bus.q_i = 32'hAAAA; tick();
      bus.ack_i = 0;
      chk("s6_ack",     bus.ack_o, 1);
      chk("s6_err_lo",  bus.err_o, 0);
      chk("s6_q",       bus.q_o, 32'hAAAA);
      chk("s6_os1",     bus.outstanding_o, 1);
      bus.ack_i = 1; bus.err_i = 1; tick();
      bus.ack_i = 0; bus.err_i = 0;
      chk("s6_err",     bus.err_o, 1);
      chk("s6_ack_lo",  bus.ack_o, 0);
      chk("s6_os0",     bus.outstanding_o, 0);
      chk("s6_empty",   bus.empty_o, 1);
      tick();
      chk("s6_err_end", bus.err_o, 0);

      // ---------------- stray completion with nothing in flight
      bus.ack_i = 1; tick();
      bus.ack_i = 0;
      chk("s7_stray_ack", bus.ack_o, 0);
      chk("s7_stray_os",  bus.outstanding_o, 0);

      // ---------------- reset mid-operation
      set_req(32'h50, SZ_WORD, 0, 0, 0); tick();
      bus.req_i = 0; tick();
      chk("s8_os1",     bus.outstanding_o, 1);
      rst = 1; tick();
      rst = 0;
      chk("s8_rst_os",  bus.outstanding_o, 0);
      chk("s8_rst_empty", bus.empty_o, 1);
      bus.ack_i = 1; tick();
      bus.ack_i = 0;
      chk("s8_late_ack", bus.ack_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
